inst_align: RTL and testbench

INST_ALIGN -- requirements
Module: inst_align

---
 rtl/inst_align.sv | 161 ++++++++++++++++
 tb/tb_inst_align.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_align.sv
// inst_align: two-word prefetch buffer that aligns 16/32-bit instructions for decode.
// Compressed instructions are supported when INST_ALIGN_COMPRESSED_EN is defined.
module inst_align #(
   parameter logic [31:0] ROM_ORI = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] fet_pc_i,
   input  logic        flush_i,
   output logic        fet_en_o,
   output logic        com_inst_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [1:0]  state_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]  state_q;
   logic        kill_q;
   logic        v0_q;
   logic        v1_q;
   logic [31:0] base_q;
   logic [31:0] buf0_q;
   logic [31:0] buf1_q;
   logic [31:0] addr_q;

   logic        pc_hit;
   logic        pc_ahead;
   logic        redirect;
   logic        is_com;
   logic        halves_ok;
   logic        next_leaves;
   logic        shift;
   logic        accept;
   logic        v0_after;
   logic        slot_free;
   logic [31:0] inst_sel;
   logic [31:0] fill_addr;
   logic [31:0] redirect_base;
   logic        unused_pc;

   assign pc_hit        = fet_pc_i[31:2] == base_q[31:2];
   assign pc_ahead      = fet_pc_i[31:2] == (base_q[31:2] + 30'd1);
   assign redirect      = flush_i | (~pc_hit & ~pc_ahead);
   assign redirect_base = {fet_pc_i[31:2], 2'b00};

`ifdef INST_ALIGN_COMPRESSED_EN
   assign unused_pc = fet_pc_i[0];

   always_comb begin
      is_com      = 1'b0;
      inst_sel    = buf0_q;
      halves_ok   = v0_q;
      next_leaves = 1'b1;
      if (!fet_pc_i[1]) begin
         is_com      = buf0_q[1:0] != 2'b11;
         inst_sel    = is_com ? {16'h0000, buf0_q[15:0]} : buf0_q;
         next_leaves = ~is_com;
      end else begin
         // A 32-bit instruction at the upper half spills into the next word.
         is_com    = buf0_q[17:16] != 2'b11;
         inst_sel  = is_com ? {16'h0000, buf0_q[31:16]} : {buf1_q[15:0], buf0_q[31:16]};
         halves_ok = v0_q & (is_com | v1_q);
      end
   end
`else
   assign unused_pc   = ^fet_pc_i[1:0];
   assign is_com      = 1'b0;
   assign inst_sel    = buf0_q;
   assign halves_ok   = v0_q;
   assign next_leaves = 1'b1;
`endif

   // Decode handshake: inst_o transfers on a cycle with inst_valid_o and inst_ready_i
   // both high; inst_valid_o never depends on inst_ready_i.
   assign inst_valid_o = pc_hit & halves_ok & ~flush_i;
   assign fet_en_o     = inst_valid_o & inst_ready_i;
   assign com_inst_o   = inst_valid_o & is_com;
   assign inst_o       = inst_sel;

   assign shift     = fet_en_o & next_leaves;
   assign v0_after  = shift ? v1_q : v0_q;
   assign accept    = (state_q == ST_WAIT) & imem_rvalid_i & ~kill_q & ~redirect;
   assign slot_free = ~(v0_q & v1_q);
   // Next word to fetch sits right after the valid words; unchanged by a same-cycle shift.
   assign fill_addr = base_q + {28'b0, v0_q & v1_q, v0_q ^ v1_q, 2'b00};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q <= ROM_ORI;
         buf0_q <= '0;
         buf1_q <= '0;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
      end else if (redirect) begin
         base_q <= redirect_base;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
      end else begin
         if (shift) begin
            buf0_q <= buf1_q;
            v0_q   <= v1_q;
            v1_q   <= 1'b0;
            base_q <= base_q + 32'd4;
         end
         if (accept) begin
            if (!v0_after) begin
               buf0_q <= imem_rdata_i;
               v0_q   <= 1'b1;
            end else begin
               buf1_q <= imem_rdata_i;
               v1_q   <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         kill_q  <= 1'b0;
         addr_q  <= ROM_ORI;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (slot_free | redirect) begin
                  state_q <= ST_REQ;
                  addr_q  <= redirect ? redirect_base : fill_addr;
               end
            end
            ST_REQ: begin
               if (redirect) kill_q <= 1'b1;
               if (imem_gnt_i) state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid_i) begin
                  state_q <= ST_IDLE;
                  kill_q  <= 1'b0;
               end else if (redirect) begin
                  kill_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign imem_req_o  = state_q == ST_REQ;
   assign imem_addr_o = addr_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_inst_align.sv
// tb_inst_align: directed and randomized checks of inst_align against an instruction-stream model.
// The model reads instructions straight out of a memory image at the fetch PC.
module tb_inst_align;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] fet_pc_i;
   logic        flush_i;
   logic        fet_en_o;
   logic        com_inst_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [1:0]  state_o;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd2;

   always #5 clk_i = ~clk_i;

   inst_align #(.ROM_ORI(32'h0000_0000)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .fet_pc_i     (fet_pc_i),
      .flush_i      (flush_i),
      .fet_en_o     (fet_en_o),
      .com_inst_o   (com_inst_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .state_o      (state_o)
   );

   logic [31:0] mem [256];
   int tests = 0;
   int fails = 0;

   // memory responder controls
   int unsigned gnt_prob;
   int unsigned lat_min;
   int unsigned lat_max;
   int          gnt_budget;
   bit          pend;
   int unsigned pend_cnt;
   logic [31:0] pend_addr;
   bit          pend_poison;
   bit          prev_req_wait;
   logic [31:0] prev_addr;

   // fetch-side model
   int unsigned rdy_prob;
   logic [31:0] pc_m;
   bit          do_flush;
   logic [31:0] flush_target;
   bit          last_en;
   logic [31:0] last_len;
   int          dispatched;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

`ifdef INST_ALIGN_COMPRESSED_EN
   function automatic logic [15:0] half_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic void model_inst(input logic [31:0] pc, output logic [31:0] ins,
                                      output logic com, output logic [31:0] len);
      logic [15:0] lo;
      lo = half_at(pc);
      if (lo[1:0] != 2'b11) begin
         ins = {16'h0000, lo};
         com = 1'b1;
         len = 32'd2;
      end else begin
         ins = {half_at(pc + 32'd2), lo};
         com = 1'b0;
         len = 32'd4;
      end
   endfunction
`else
   function automatic void model_inst(input logic [31:0] pc, output logic [31:0] ins,
                                      output logic com, output logic [31:0] len);
      ins = mem[pc[9:2]];
      com = 1'b0;
      len = 32'd4;
   endfunction
`endif

   // One clock cycle: advance the model, drive memory and fetch inputs, check outputs.
   task automatic tick();
      logic [31:0] ei;
      logic        ec;
      logic [31:0] el;
      @(posedge clk_i);
      #1;
      if (last_en) pc_m = pc_m + last_len;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom();
      if (pend) begin
         if (pend_cnt <= 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = pend_poison ? 32'hBAD0_BAD3 : mem[pend_addr[9:2]];
            pend = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      if (prev_req_wait) begin
         check("req_held", 32'(imem_req_o), 32'd1);
         check("addr_stable", imem_addr_o, prev_addr);
      end
      if (imem_req_o) check("addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
      imem_gnt_i = 1'b0;
      if (imem_req_o && !pend && gnt_budget != 0 && $urandom_range(99) < gnt_prob) begin
         imem_gnt_i  = 1'b1;
         pend        = 1'b1;
         pend_cnt    = $urandom_range(lat_max, lat_min);
         pend_addr   = imem_addr_o;
         pend_poison = 1'b0;
         if (gnt_budget > 0) gnt_budget--;
      end
      prev_req_wait = imem_req_o && !imem_gnt_i;
      prev_addr     = imem_addr_o;
      if (do_flush) begin
         flush_i      = 1'b1;
         pc_m         = flush_target;
         inst_ready_i = 1'b0;
         do_flush     = 1'b0;
      end else begin
         flush_i      = 1'b0;
         inst_ready_i = $urandom_range(99) < rdy_prob;
      end
      fet_pc_i = pc_m;
      #1;
      model_inst(pc_m, ei, ec, el);
      if (inst_valid_o) begin
         check("inst", inst_o, ei);
         check("com", 32'(com_inst_o), 32'(ec));
      end
      if (!inst_ready_i) check("en_no_ready", 32'(fet_en_o), 32'd0);
      if (fet_en_o) begin
         check("en_valid", 32'(inst_valid_o), 32'd1);
         dispatched++;
      end
      last_en  = flush_i ? 1'b0 : fet_en_o;
      last_len = el;
   endtask

   task automatic do_reset(input logic [31:0] start_pc, input bit late_resp);
      @(negedge clk_i);
      rst_ni        = 1'b0;
      flush_i       = 1'b0;
      inst_ready_i  = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      fet_pc_i      = start_pc;
      #1;
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_en", 32'(fet_en_o), 32'd0);
      check("rst_com", 32'(com_inst_o), 32'd0);
      check("rst_state", 32'(state_o), 32'(S_IDLE));
      if (late_resp) begin
         pend        = 1'b1;
         pend_cnt    = 1;
         pend_poison = 1'b1;
      end else begin
         pend = 1'b0;
      end
      repeat (2) @(negedge clk_i);
      rst_ni        = 1'b1;
      pc_m          = start_pc;
      last_en       = 1'b0;
      last_len      = 32'd4;
      prev_req_wait = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n = 0;
      while (!inst_valid_o && n < limit) begin
         tick();
         n++;
      end
      check(tag, 32'(inst_valid_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ei;
      logic        ec;
      logic [31:0] el;
      int          n;
      rst_ni = 1'b0; fet_pc_i = '0; flush_i = 1'b0; inst_ready_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      pend = 1'b0; pend_cnt = 0; pend_addr = '0; pend_poison = 1'b0;
      prev_req_wait = 1'b0; prev_addr = '0; do_flush = 1'b0; flush_target = '0;
      last_en = 1'b0; last_len = 32'd4; pc_m = '0; dispatched = 0;
      gnt_budget = -1; gnt_prob = 100; lat_min = 1; lat_max = 1; rdy_prob = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom();

      // reset release and first fetch
      mem[0] = 32'h0000_0013;
      do_reset(32'h0, 1'b0);
      tick();
      check("first_req", 32'(imem_req_o), 32'd1);
      check("first_addr", imem_addr_o, 32'h0);
      tick();
      check("lat_wait", 32'(inst_valid_o), 32'd0);
      tick();
      check("lat_valid", 32'(inst_valid_o), 32'd1);
      check("first_inst", inst_o, 32'h0000_0013);
      check("first_com", 32'(com_inst_o), 32'd0);

      // backpressure with both slots full
      repeat (8) tick();
      repeat (5) begin
         tick();
         check("bp_req", 32'(imem_req_o), 32'd0);
         check("bp_en", 32'(fet_en_o), 32'd0);
         check("bp_inst", inst_o, 32'h0000_0013);
      end
      rdy_prob = 100;
      tick();
      check("b2b_first", 32'(fet_en_o), 32'd1);
      tick();
      check("b2b_next", 32'(inst_valid_o), 32'd1);

`ifdef INST_ALIGN_COMPRESSED_EN
      // compressed pair in one word
      mem[0] = 32'h4501_4581;
      rdy_prob = 0;
      do_reset(32'h0, 1'b0);
      repeat (8) tick();
      rdy_prob = 100;
      tick();
      check("pair_v0", 32'(inst_valid_o), 32'd1);
      check("pair_i0", inst_o, 32'h0000_4581);
      check("pair_c0", 32'(com_inst_o), 32'd1);
      tick();
      check("pair_v1", 32'(inst_valid_o), 32'd1);
      check("pair_i1", inst_o, 32'h0000_4501);
      check("pair_c1", 32'(com_inst_o), 32'd1);
      tick();
      check("pair_shift", 32'(inst_valid_o), 32'd1);

      // spanning instruction waits for the second word
      mem[0] = 32'h0297_0001;
      mem[1] = 32'h1234_0000;
      gnt_budget = 1;
      do_reset(32'h2, 1'b0);
      repeat (6) begin
         tick();
         check("span_wait", 32'(inst_valid_o), 32'd0);
      end
      gnt_budget = -1;
      wait_valid("span_valid", 10);
      check("span_inst", inst_o, 32'h0000_0297);
      check("span_com", 32'(com_inst_o), 32'd0);
`else
      // PC bit 1 ignored without compressed support
      mem[0] = 32'h0041_8193;
      rdy_prob = 0;
      do_reset(32'h2, 1'b0);
      wait_valid("nc_valid", 10);
      check("nc_inst", inst_o, 32'h0041_8193);
      check("nc_com", 32'(com_inst_o), 32'd0);
`endif

      // reset in the middle of a request; late response must be ignored
      rdy_prob = 0; lat_min = 3; lat_max = 3;
      do_reset(32'h0, 1'b0);
      tick();
      tick();
      check("wait_state", 32'(state_o), 32'(S_WAIT));
      lat_min = 1; lat_max = 1;
      do_reset(32'h0, 1'b1);
      wait_valid("post_rst_valid", 10);
      model_inst(32'h0, ei, ec, el);
      check("post_rst_inst", inst_o, ei);

      // flush during WAIT
      lat_min = 3; lat_max = 3;
      do_reset(32'h0, 1'b0);
      n = 0;
      while (state_o != S_WAIT && n < 20) begin
         tick();
         n++;
      end
      check("reach_wait", 32'(state_o), 32'(S_WAIT));
      flush_target = 32'h100;
      do_flush = 1'b1;
      tick();
      n = 0;
      while (!imem_req_o && n < 20) begin
         tick();
         check("no_stale", 32'(inst_valid_o), 32'd0);
         n++;
      end
      check("flush_addr", imem_addr_o, 32'h100);
      lat_min = 1;
      wait_valid("flush_refill", 20);
      check("flush_inst", inst_o, mem[64]);

      // randomized traffic with occasional redirects
      gnt_prob = 70; lat_min = 1; lat_max = 3; rdy_prob = 75; gnt_budget = -1;
      do_reset(32'h0, 1'b0);
      dispatched = 0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(99) < 3) begin
            do_flush = 1'b1;
            flush_target = 32'($urandom_range(511)) << 1;
         end
         tick();
      end
      check("liveness", 32'(dispatched >= 40), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
